// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among NUM_REQ requesters, round-robin per message.
// Each accepted byte costs ARM/STROBE/GAP; grants release on last byte, MAX_BURST or idle TIMEOUT.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_txd,
  output logic                 uart_txd_strobe,
  input  logic                 uart_txd_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, STROBE, GAP} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [IW-1:0]      last_grant, last_grant_nxt;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [7:0]         burst_cnt, burst_nxt;
  logic [7:0]         tmo_cnt, tmo_nxt;
  logic [7:0]         txd_nxt;
  logic               strobe_nxt;
  logic               last_lat, last_nxt;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;

  assign busy = (state != IDLE);

  // Round-robin pick: scan far-to-near so the nearest valid requester after last_grant wins.
  always_comb begin
    pick_idx = last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(last_grant) + k) % NUM_REQ && req_valid[i]) pick_idx = IW'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    gidx_nxt       = gidx;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    burst_nxt      = burst_cnt;
    tmo_nxt        = tmo_cnt;
    txd_nxt        = uart_txd;
    strobe_nxt     = 1'b0;
    last_nxt       = last_lat;
    req_ready      = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = ARM;
          gidx_nxt  = pick_idx;
          grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          burst_nxt = 8'h00;
          tmo_nxt   = 8'h00;
        end
      end
      ARM: begin
        if (sel_valid) begin
          // Waiting on the UART neither advances nor clears the idle timer.
          if (uart_txd_ready) begin
            req_ready  = grant;
            txd_nxt    = sel_data;
            strobe_nxt = 1'b1;
            last_nxt   = sel_last;
            burst_nxt  = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
            state_nxt  = STROBE;
          end
        end else if ({1'b0, tmo_cnt} + 9'd1 >= 9'(TIMEOUT)) begin
          state_nxt      = IDLE;
          last_grant_nxt = gidx;
          grant_nxt      = '0;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end
      STROBE: state_nxt = GAP;
      GAP: begin
        // GAP spans the UART's ready-deassert delay, so release only happens here.
        if (last_lat || burst_cnt == 8'(MAX_BURST)) begin
          state_nxt      = IDLE;
          last_grant_nxt = gidx;
          grant_nxt      = '0;
        end else begin
          state_nxt = ARM;
          tmo_nxt   = 8'h00;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      gidx            <= '0;
      grant           <= '0;
      last_grant      <= IW'(NUM_REQ - 1);
      burst_cnt       <= 8'h00;
      tmo_cnt         <= 8'h00;
      uart_txd        <= 8'h00;
      uart_txd_strobe <= 1'b0;
      last_lat        <= 1'b0;
    end else begin
      state           <= state_nxt;
      gidx            <= gidx_nxt;
      grant           <= grant_nxt;
      last_grant      <= last_grant_nxt;
      burst_cnt       <= burst_nxt;
      tmo_cnt         <= tmo_nxt;
      uart_txd        <= txd_nxt;
      uart_txd_strobe <= strobe_nxt;
      last_lat        <= last_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the inputs,
// every cycle is logged at the falling edge and scenarios compare against hand-computed timelines.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_txd;
  logic           uart_txd_strobe;
  logic           uart_txd_ready;
  logic [N-1:0]   grant;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16), .TIMEOUT(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .uart_txd        (uart_txd),
    .uart_txd_strobe (uart_txd_strobe),
    .uart_txd_ready  (uart_txd_ready),
    .grant           (grant),
    .busy            (busy)
  );

  logic [7:0]   qd [N][64];
  logic         ql [N][64];
  int           qh [N];
  int           qt [N];

  int           cyc;
  int           log_n;
  logic [7:0]   log_dat [64];
  int           log_cyc [64];
  logic [N-1:0] log_gnt [64];
  logic         busy_log [256];
  logic         stb_log  [256];
  logic [N-1:0] gnt_log  [256];
  logic [N-1:0] rdy_log  [256];
  logic [7:0]   txd_log  [256];

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
  endtask

  task automatic clear_logs();
    cyc   = 0;
    log_n = 0;
    for (int i = 0; i < 64; i++) begin
      log_dat[i] = 8'h00;
      log_cyc[i] = -1;
      log_gnt[i] = '0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][qt[r]] = d;
    ql[r][qt[r]] = l;
    qt[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = qd[i][qh[i]];
        req_last[i]        = ql[i][qh[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Sample on the falling edge, advance queues on accepted bytes just after the rising edge.
  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (cyc < 256) begin
        busy_log[cyc] = busy;
        stb_log[cyc]  = uart_txd_strobe;
        gnt_log[cyc]  = grant;
        rdy_log[cyc]  = req_ready;
        txd_log[cyc]  = uart_txd;
      end
      if (uart_txd_strobe && log_n < 64) begin
        log_dat[log_n] = uart_txd;
        log_cyc[log_n] = cyc;
        log_gnt[log_n] = grant;
        log_n++;
      end
      n_chk++;
      if (!$onehot0(req_ready) || (req_ready & ~grant) != '0) begin
        n_fail++;
        $display("FAIL ready_onehot cyc=%0d: req_ready=%b grant=%b, want at most the granted bit", cyc, req_ready, grant);
      end
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) qh[i]++;
      drive();
      cyc++;
    end
  endtask

  task automatic do_reset();
    clear_queues();
    drive();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_queues();
    drive();
    uart_txd_ready = 1'b1;
    reset_n        = 1'b0;
    req_valid      = '1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (uart_txd_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b want 0", uart_txd_strobe); end
    n_chk++; if (uart_txd !== 8'h00) begin n_fail++; $display("FAIL rst_txd: got %h want 00", uart_txd); end
    n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d [3] = '{8'h48, 8'h69, 8'h0A};
    clear_logs();
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b0);
    push(0, 8'h0A, 1'b1);
    reset_n = 1'b1;
    drive();
    run_cycles(12);
    n_chk++; if (rdy_log[1] !== 4'b0001) begin n_fail++; $display("FAIL single_ready_lat: got %b want 0001", rdy_log[1]); end
    n_chk++; if (log_n !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", log_n); end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (log_dat[i] !== exp_d[i] || log_cyc[i] !== 2 + 3*i || log_gnt[i] !== 4'b0001) begin
        n_fail++;
        $display("FAIL single_strobe%0d: got %h@%0d g=%b want %h@%0d g=0001", i, log_dat[i], log_cyc[i], log_gnt[i], exp_d[i], 2 + 3*i);
      end
    end
    n_chk++; if (txd_log[3] !== 8'h48) begin n_fail++; $display("FAIL single_txd_hold: got %h want 48", txd_log[3]); end
    n_chk++; if (busy_log[10] !== 1'b0 || gnt_log[10] !== 4'b0000) begin n_fail++; $display("FAIL single_idle: got busy=%b grant=%b want 0 0000", busy_log[10], gnt_log[10]); end
  endtask

  task automatic test_round_robin();
    logic [7:0]   ed;
    logic [N-1:0] eg;
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(0, 8'h10 + 8'(k), 1'b1);
      push(2, 8'h20 + 8'(k), 1'b1);
    end
    drive();
    run_cycles(34);
    n_chk++; if (log_n !== 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", log_n); end
    for (int k = 0; k < 8; k++) begin
      ed = (k % 2 == 0) ? 8'h10 + 8'(k/2) : 8'h20 + 8'(k/2);
      eg = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      n_chk++;
      if (log_dat[k] !== ed || log_gnt[k] !== eg || log_cyc[k] !== 2 + 4*k) begin
        n_fail++;
        $display("FAIL rr_strobe%0d: got %h@%0d g=%b want %h@%0d g=%b", k, log_dat[k], log_cyc[k], log_gnt[k], ed, 2 + 4*k, eg);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0]   ed;
    logic [N-1:0] eg;
    int           ec;
    do_reset();
    clear_logs();
    for (int i = 0; i < 20; i++) push(1, 8'h80 + 8'(i), 1'b0);
    push(3, 8'hC0, 1'b1);
    drive();
    run_cycles(72);
    n_chk++; if (log_n !== 21) begin n_fail++; $display("FAIL burst_count: got %0d want 21", log_n); end
    for (int i = 0; i < 21; i++) begin
      if (i < 16) begin
        ed = 8'h80 + 8'(i); ec = 2 + 3*i; eg = 4'b0010;
      end else if (i == 16) begin
        ed = 8'hC0; ec = 51; eg = 4'b1000;
      end else begin
        ed = 8'h90 + 8'(i - 17); ec = 55 + 3*(i - 17); eg = 4'b0010;
      end
      n_chk++;
      if (log_dat[i] !== ed || log_cyc[i] !== ec || log_gnt[i] !== eg) begin
        n_fail++;
        $display("FAIL burst_strobe%0d: got %h@%0d g=%b want %h@%0d g=%b", i, log_dat[i], log_cyc[i], log_gnt[i], ed, ec, eg);
      end
    end
    n_chk++; if (busy_log[49] !== 1'b0 || gnt_log[49] !== 4'b0000) begin n_fail++; $display("FAIL burst_release: got busy=%b grant=%b want 0 0000", busy_log[49], gnt_log[49]); end
    n_chk++; if (busy_log[69] !== 1'b1 || busy_log[70] !== 1'b0) begin n_fail++; $display("FAIL burst_tail_timeout: got busy69=%b busy70=%b want 1 0", busy_log[69], busy_log[70]); end
  endtask

  task automatic test_timeout();
    do_reset();
    clear_logs();
    push(3, 8'h55, 1'b0);
    drive();
    run_cycles(1);
    qh[3] = qt[3];
    drive();
    run_cycles(8);
    n_chk++; if (gnt_log[1] !== 4'b1000) begin n_fail++; $display("FAIL tmo_grant: got %b want 1000", gnt_log[1]); end
    n_chk++; if (busy_log[4] !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got busy=%b want 1", busy_log[4]); end
    n_chk++; if (busy_log[5] !== 1'b0 || gnt_log[5] !== 4'b0000) begin n_fail++; $display("FAIL tmo_release: got busy=%b grant=%b want 0 0000", busy_log[5], gnt_log[5]); end
    n_chk++; if (log_n !== 0) begin n_fail++; $display("FAIL tmo_nostrobe: got %0d strobes want 0", log_n); end
  endtask

  task automatic test_ready_low();
    do_reset();
    clear_logs();
    uart_txd_ready = 1'b0;
    push(0, 8'h5A, 1'b1);
    drive();
    run_cycles(101);
    uart_txd_ready = 1'b1;
    run_cycles(6);
    n_chk++; if (busy_log[100] !== 1'b1 || gnt_log[100] !== 4'b0001) begin n_fail++; $display("FAIL stall_hold: got busy=%b grant=%b want 1 0001", busy_log[100], gnt_log[100]); end
    n_chk++; if (rdy_log[100] !== 4'b0000 || rdy_log[101] !== 4'b0001) begin n_fail++; $display("FAIL stall_ready: got %b,%b want 0000,0001", rdy_log[100], rdy_log[101]); end
    n_chk++; if (log_n !== 1 || log_cyc[0] !== 102 || log_dat[0] !== 8'h5A) begin n_fail++; $display("FAIL stall_strobe: got n=%0d %h@%0d want n=1 5a@102", log_n, log_dat[0], log_cyc[0]); end
  endtask

  task automatic test_reset_in_strobe();
    do_reset();
    clear_logs();
    push(2, 8'h31, 1'b0);
    push(2, 8'h32, 1'b1);
    drive();
    run_cycles(2);
    n_chk++; if (uart_txd_strobe !== 1'b1 || grant !== 4'b0100) begin n_fail++; $display("FAIL rs_pre: got strobe=%b grant=%b want 1 0100", uart_txd_strobe, grant); end
    push(0, 8'h41, 1'b1);
    reset_n = 1'b0;
    drive();
    run_cycles(2);
    reset_n = 1'b1;
    run_cycles(10);
    n_chk++; if (stb_log[3] !== 1'b0 || gnt_log[3] !== 4'b0000 || busy_log[3] !== 1'b0) begin n_fail++; $display("FAIL rs_drop: got strobe=%b grant=%b busy=%b want 0 0000 0", stb_log[3], gnt_log[3], busy_log[3]); end
    n_chk++; if (gnt_log[5] !== 4'b0001) begin n_fail++; $display("FAIL rs_first_arb: got %b want 0001", gnt_log[5]); end
    n_chk++; if (log_n !== 3) begin n_fail++; $display("FAIL rs_count: got %0d want 3", log_n); end
    n_chk++; if (log_dat[1] !== 8'h41 || log_cyc[1] !== 6 || log_gnt[1] !== 4'b0001) begin n_fail++; $display("FAIL rs_req0: got %h@%0d g=%b want 41@6 g=0001", log_dat[1], log_cyc[1], log_gnt[1]); end
    n_chk++; if (log_dat[2] !== 8'h32 || log_cyc[2] !== 10 || log_gnt[2] !== 4'b0100) begin n_fail++; $display("FAIL rs_req2: got %h@%0d g=%b want 32@10 g=0100", log_dat[2], log_cyc[2], log_gnt[2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_timeout();
    test_ready_low();
    test_reset_in_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter, 2..8.
REQ-002 Parameter MAX_BURST, default 16: maximum bytes per grant before forced release, 1..255.
REQ-003 Parameter TIMEOUT, default 255: idle cycles tolerated on a granted requester before release, 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  bit i: requester i presents a byte.
REQ-007 req_data  input  8*NUM_REQ  byte of requester i at [8*i+7:8*i].
REQ-008 req_last  input  NUM_REQ  bit i: presented byte ends requester i's message.
REQ-009 req_ready  output  NUM_REQ  combinational; bit i high in the cycle requester i's byte is accepted.
REQ-010 uart_txd  output  8  registered byte to the UART transmitter.
REQ-011 uart_txd_strobe  output  1  registered one-cycle load pulse to the UART.
REQ-012 uart_txd_ready  input  1  UART transmitter idle and able to load a byte.
REQ-013 grant  output  NUM_REQ  registered one-hot owner; all zero when idle.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ARM, STROBE and GAP.
REQ-016 IDLE: if any req_valid is set, the next state SHALL be ARM with grant set to the first valid requester searching from last_grant+1 upward, wrapping modulo NUM_REQ; the burst and timeout counters SHALL clear.
REQ-017 ARM accept: when req_valid[g] and uart_txd_ready are both set, the block SHALL assert req_ready[g] combinationally, register uart_txd<=req_data[g], set uart_txd_strobe<=1, and enter STROBE.
REQ-018 ARM idle: when req_valid[g] is low, the timeout counter SHALL increment; on reaching TIMEOUT the block SHALL release (REQ-022) with no byte sent.
REQ-019 ARM wait: when uart_txd_ready is low and req_valid[g] is high, the block SHALL hold in ARM, and the timeout counter SHALL neither increment nor clear.
REQ-020 STROBE: uart_txd_strobe SHALL be high for exactly this one cycle, then GAP; req_ready SHALL be all zero.
REQ-021 GAP: one cycle in which no accept occurs and uart_txd_ready is ignored, covering the UART's ready-deassert delay; the burst counter SHALL have incremented on accept.
REQ-022 Release: leaving GAP, if the accepted byte had req_last set or the burst count equals MAX_BURST, the block SHALL go to IDLE, set last_grant<=g and clear grant; otherwise it SHALL return to ARM with the timeout counter cleared.
REQ-023 Release SHALL take effect only after GAP, never mid-byte, so a released requester cannot be re-granted before the UART has loaded its last byte.
REQ-024 At most one req_ready bit SHALL be high in any cycle, and only for the current grant.
REQ-025 uart_txd SHALL hold its last value when strobe is low.
REQ-026 Minimum spacing between strobes SHALL be 3 cycles: ARM, STROBE, GAP.
REQ-027 Latency SHALL be as follows: with the block in IDLE and uart_txd_ready high, req_valid sampled at edge N gives req_ready in cycle N+1 and strobe high in cycle N+2.
REQ-028 req_valid changes of non-granted requesters SHALL have no effect until the next IDLE.
REQ-029 The burst counter SHALL be at least 8 bits wide and SHALL never wrap; release at MAX_BURST SHALL be exact.

Reset
REQ-030 While reset_n is low at a clock edge, the block SHALL set state IDLE, uart_txd_strobe 0, uart_txd 0x00, grant 0, busy 0, both counters 0, and last_grant NUM_REQ-1 so that requester 0 has priority first.
REQ-031 Reset in any state SHALL drop a strobe in the following cycle and discard any in-flight byte; req_ready SHALL be 0 while reset_n is low.

Verification
REQ-032 Single requester, all req_valid rising together, 3-byte message 0x48,0x69,0x0A with last on 0x0A, ready held 1 -> grant=0001; strobes carry 0x48,0x69,0x0A exactly 3 cycles apart; IDLE after GAP.
REQ-033 Requesters 0 and 2 valid continuously with 1-byte messages -> grants alternate 0,2,0,2; no requester is granted twice in a row while the other waits.
REQ-034 Requester 1 streams 20 bytes without last, MAX_BURST=16 -> release after the 16th strobe; requester 1 is re-granted only after other valid requesters are served.
REQ-035 Requester 3 granted, then drops valid without last, TIMEOUT=4 -> IDLE after 4 ARM cycles; no strobe; grant=0.
REQ-036 uart_txd_ready held low 100 cycles during ARM with valid high -> no strobe and no timeout; first strobe in the cycle after ready rises plus one.
REQ-037 reset_n driven low during STROBE -> strobe 0 and grant 0 on the next cycle; after release, requester 0 wins the first arbitration.
